// File: rtl/alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_arbiter_pkg : shared func codes, FSM encoding and flag positions
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_arbiter_pkg;

  localparam int c_FUNC_W = 6;

  localparam logic [c_FUNC_W-1:0] c_FUNC_SLLV   = 6'b000100;
  localparam logic [c_FUNC_W-1:0] c_FUNC_SRLV   = 6'b000110;
  localparam logic [c_FUNC_W-1:0] c_FUNC_SRAV   = 6'b000111;
  localparam logic [c_FUNC_W-1:0] c_FUNC_MUL    = 6'b001110;
  localparam logic [c_FUNC_W-1:0] c_FUNC_ALU_LO = 6'b100000;
  localparam logic [c_FUNC_W-1:0] c_FUNC_ALU_HI = 6'b100110;
  localparam logic [c_FUNC_W-1:0] c_FUNC_CMP_LO = 6'b101000;
  localparam logic [c_FUNC_W-1:0] c_FUNC_CMP_HI = 6'b101101;

  localparam int c_FLAG_Z = 3;
  localparam int c_FLAG_V = 2;
  localparam int c_FLAG_C = 1;
  localparam int c_FLAG_N = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MULT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  function automatic logic func_is_legal(input logic [c_FUNC_W-1:0] f);
    return (f == c_FUNC_SLLV) || (f == c_FUNC_SRLV) || (f == c_FUNC_SRAV) ||
           (f == c_FUNC_MUL) ||
           ((f >= c_FUNC_ALU_LO) && (f <= c_FUNC_ALU_HI)) ||
           ((f >= c_FUNC_CMP_LO) && (f <= c_FUNC_CMP_HI));
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if : requester, shared-ALU and response signals of alu_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_arbiter_if;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_d1;
  logic [63:0] req_d2;
  logic [11:0] req_func;

  logic [31:0] alu_d1;
  logic [31:0] alu_d2;
  logic [5:0]  alu_func;
  logic [31:0] alu_s;
  logic        alu_zero;
  logic        alu_ovf;
  logic        alu_cout;
  logic        alu_n;

  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_s;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic        busy;

  // Master side plays both the requesters and the shared ALU.
  modport master (
    output req_valid, req_d1, req_d2, req_func,
    output alu_s, alu_zero, alu_ovf, alu_cout, alu_n,
    output rsp_ready,
    input  req_ready, alu_d1, alu_d2, alu_func,
    input  rsp_valid, rsp_s, rsp_flags, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_d1, req_d2, req_func,
    input  alu_s, alu_zero, alu_ovf, alu_cout, alu_n,
    input  rsp_ready,
    output req_ready, alu_d1, alu_d2, alu_func,
    output rsp_valid, rsp_s, rsp_flags, rsp_err, busy
  );

endinterface

`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 : two-way round-robin arbiter producing a one-hot grant
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
  input  wire logic [1:0] i_req,
  input  wire logic       i_last_grant,
  output logic      [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter : shares one ALU between two requesters with round-robin grant
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int MULT_CYCLES = 4
) (
  input wire logic     clk,
  input wire logic     reset,
  alu_arbiter_if.slave bus
);

  localparam logic [3:0] c_MULT_LOAD = 4'(MULT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_grant;
  logic        r_id;
  logic [3:0]  r_cnt;
  logic [31:0] r_alu_d1;
  logic [31:0] r_alu_d2;
  logic [5:0]  r_alu_func;
  logic [31:0] r_rsp_s;
  logic [3:0]  r_rsp_flags;
  logic        r_rsp_err;

  logic [1:0]  w_grant;
  logic [1:0]  w_ready;
  logic [1:0]  w_accept;
  logic        w_acc_any;
  logic        w_sel;
  logic [31:0] w_d1;
  logic [31:0] w_d2;
  logic [5:0]  w_func;
  logic        w_legal;
  logic        w_capture;

  rr_arb2 u_rr_arb2 (
    .i_req        (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_ready   = ((r_state == S_IDLE) && !reset) ? w_grant : 2'b00;
  assign w_accept  = bus.req_valid & w_ready;
  assign w_acc_any = |w_accept;
  assign w_sel     = w_accept[1];
  assign w_d1      = w_sel ? bus.req_d1[63:32]  : bus.req_d1[31:0];
  assign w_d2      = w_sel ? bus.req_d2[63:32]  : bus.req_d2[31:0];
  assign w_func    = w_sel ? bus.req_func[11:6] : bus.req_func[5:0];
  assign w_legal   = func_is_legal(w_func);
  assign w_capture = (r_state == S_EXEC) || ((r_state == S_MULT) && (r_cnt == 4'd0));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc_any) begin
          if (!w_legal)                  w_state_nxt = S_RESP;
          else if (w_func == c_FUNC_MUL) w_state_nxt = S_MULT;
          else                           w_state_nxt = S_EXEC;
        end
      end
      S_EXEC:  w_state_nxt = S_RESP;
      S_MULT:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready[r_id]) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_cnt        <= 4'd0;
      r_alu_d1     <= 32'd0;
      r_alu_d2     <= 32'd0;
      r_alu_func   <= 6'd0;
      r_rsp_s      <= 32'd0;
      r_rsp_flags  <= 4'd0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_acc_any) begin
        r_alu_d1     <= w_d1;
        r_alu_d2     <= w_d2;
        r_alu_func   <= w_func;
        r_id         <= w_sel;
        r_last_grant <= w_sel;
        r_rsp_err    <= !w_legal;
        if (w_func == c_FUNC_MUL) begin
          r_cnt <= c_MULT_LOAD;
        end
        // Illegal codes answer immediately with a zeroed result.
        if (!w_legal) begin
          r_rsp_s     <= 32'd0;
          r_rsp_flags <= 4'd0;
        end
      end
      if ((r_state == S_MULT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_rsp_s               <= bus.alu_s;
        r_rsp_flags[c_FLAG_Z] <= bus.alu_zero;
        r_rsp_flags[c_FLAG_V] <= bus.alu_ovf;
        r_rsp_flags[c_FLAG_C] <= bus.alu_cout;
        r_rsp_flags[c_FLAG_N] <= bus.alu_n;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.alu_d1    = r_alu_d1;
  assign bus.alu_d2    = r_alu_d2;
  assign bus.alu_func  = r_alu_func;
  assign bus.rsp_valid = (r_state == S_RESP) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_s     = r_rsp_s;
  assign bus.rsp_flags = r_rsp_flags;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter MULT_CYCLES, default 4, number of cycles the ALU is held for func 6'b001110 (multiply); legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  2  bit i = requester i presents an operation.
REQ-005 req_ready  out  2  bit i = arbiter accepts requester i this cycle.
REQ-006 req_d1  in  64  operand A; [31:0] requester 0, [63:32] requester 1.
REQ-007 req_d2  in  64  operand B, same packing.
REQ-008 req_func  in  12  6-bit ALU function code; [5:0] requester 0, [11:6] requester 1.
REQ-009 alu_d1 / alu_d2  out  32 each  registered operands driven to the shared ALU.
REQ-010 alu_func  out  6  registered function code to the ALU.
REQ-011 alu_s  in  32  ALU result; alu_zero, alu_ovf, alu_cout, alu_n  in  1 each  ALU flags.
REQ-012 rsp_valid  out  2  bit i = response pending for requester i.
REQ-013 rsp_ready  in  2  bit i = requester i consumes its response.
REQ-014 rsp_s  out  32  captured result; rsp_flags  out  4  {Z,V,C,N}; rsp_err  out  1  illegal func.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, MULT, RESP.
REQ-017 IDLE: req_ready SHALL equal the one-hot grant of the round-robin arbiter over req_valid; all other states drive req_ready = 2'b00.
REQ-018 Arbitration: a single valid requester wins; with both valid, the requester not granted last wins; last_grant updates only on acceptance.
REQ-019 On acceptance (req_valid[i] & req_ready[i]), operands and func of requester i SHALL be registered onto alu_d1/alu_d2/alu_func and the grant id stored.
REQ-020 Legal funcs: 000100, 000110, 000111, 100000-100110, 101000-101101, 001110; any other code SHALL set rsp_err=1, rsp_s=0, rsp_flags=0 and go IDLE->RESP without entering EXEC.
REQ-021 Legal non-multiply func: IDLE->EXEC; at end of EXEC, alu_s and flags captured into rsp_s/rsp_flags; EXEC->RESP.
REQ-022 Multiply: IDLE->MULT; counter loads MULT_CYCLES-1, decrements each cycle; capture and MULT->RESP when counter is 0 (ALU inputs held stable for exactly MULT_CYCLES cycles).
REQ-023 Latency from acceptance cycle N: rsp_valid high at N+2 (normal), N+1+MULT_CYCLES (multiply), N+1 (illegal).
REQ-024 RESP: rsp_valid[id]=1, other bit 0; rsp_s/rsp_flags/rsp_err stable until rsp_ready[id]=1, then RESP->IDLE next cycle.
REQ-025 rsp_ready on the non-owning bit SHALL be ignored; a new request is accepted no earlier than the cycle after response handshake (no bypass).
REQ-026 alu_d1/alu_d2/alu_func SHALL hold their last value outside acceptance (no toggling while idle).
REQ-027 req_valid deasserted in IDLE causes no state change.

Reset
REQ-028 reset SHALL force IDLE, req_ready=0, rsp_valid=0, rsp_s=0, rsp_flags=0, rsp_err=0, alu_d1=0, alu_d2=0, alu_func=0, counter=0, busy=0, last_grant=1 (requester 0 wins first tie).
REQ-029 reset asserted in EXEC, MULT or RESP SHALL abandon the operation; no response is issued for it afterward.

Structure
REQ-030 Shared package SHALL hold the 6-bit func code constants, the FSM state encoding and the flag bit positions.
REQ-031 Round-robin logic SHALL be one sub-module rr_arb2 (req[1:0], last_grant -> one-hot grant).

Verification
REQ-032 Req0 only, d1=5, d2=3, func=100000, ALU returns 8 -> rsp_valid=2'b01 at N+2, rsp_s=8, rsp_flags=4'b0000.
REQ-033 Both valid every cycle from reset, func=100010 -> grants alternate 0,1,0,1; each response on the correct bit.
REQ-034 Req1 multiply d1=6, d2=7, MULT_CYCLES=4 -> alu_func=001110 stable for 4 cycles, rsp_valid=2'b10 at N+5, rsp_s=42.
REQ-035 Req0 func=111111 -> rsp_valid=2'b01 at N+1, rsp_err=1, rsp_s=0; ALU result ignored.
REQ-036 Hold rsp_ready=0 for 10 cycles in RESP, pulse rsp_ready[1] on req0's response -> outputs stable, no new grant; rsp_ready[0] then IDLE.
REQ-037 Assert reset during MULT cycle 2 -> next cycle IDLE, all outputs 0, no response ever asserted for that op.
